uart_rx_capture: RTL and testbench

//   Serial receive path for the tile: the inbound counterpart to the tile's output drive. Deserialises
//   8N1 UART frames from one dedicated input pin (ui_in bit chosen at top level) into bytes.

---
 rtl/uart_rx_capture.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_capture.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_capture.sv
// uart_rx_capture
//   8N1 UART receiver. The asynchronous serial line rx_in passes through a
//   two-flop synchroniser and is sampled mid-bit by a small FSM. Each good byte
//   is presented on a single-entry valid/ready holding register. A low stop bit
//   raises a one-cycle framing-error pulse. A good byte that arrives while the
//   holding register is still full sets a sticky overrun flag.
//
//   Ports
//     clk         rising-edge clock for all logic
//     reset       synchronous, active-high
//     ena         blocks the start of a new frame while low
//     rx_in       serial line input, idle high
//     data_out    received byte, LSB = first data bit
//     data_valid  holding register full
//     data_ready  consumer accept; transfer on data_valid & data_ready
//     frame_err   one-cycle pulse when a stop bit is sampled low
//     overrun     sticky: a good byte was dropped because the register was full
//     busy        FSM is not in IDLE
module uart_rx_capture #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  // The start bit is checked half a bit in, so every later sample lands mid-bit.
  localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  logic          rx_meta_q, rx_s_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          ovr_q, ovr_d;

  logic sample;
  logic deliver;
  logic bad_stop;
  logic hs;
  logic accept;

  // Synchroniser: reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign sample = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    deliver  = 1'b0;
    bad_stop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ena && !rx_s_q) begin
          state_d = S_START;
          cnt_d   = HALF_LD;
          bit_d   = 3'd0;
        end
      end
      S_START: begin
        if (sample) begin
          if (rx_s_q) begin
            // Line went back high before mid-start-bit: a glitch, not a frame.
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = FULL_LD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (sample) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = FULL_LD;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        if (sample) begin
          if (rx_s_q) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            bad_stop = 1'b1;
            state_d  = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WAIT_IDLE: begin
        // A held-low line (break) must return high before a new start is accepted.
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Holding register: a delivery is accepted when the slot is empty or is being
  // emptied by a handshake in the same cycle; otherwise the byte is dropped.
  always_comb begin
    hs      = valid_q & data_ready;
    accept  = deliver & (~valid_q | hs);
    data_d  = accept ? shift_q : data_q;
    valid_d = valid_q;
    if (accept)  valid_d = 1'b1;
    else if (hs) valid_d = 1'b0;
    ovr_d = ovr_q;
    if (deliver && !accept) ovr_d = 1'b1;
    else if (hs)            ovr_d = 1'b0;
    fe_d = bad_stop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  // Shift register holds only in-flight data; a partial byte is never visible.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = fe_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_capture.sv
module tb_uart_rx_capture;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ena = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready = 1'b1;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int fe_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx_capture #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .ena(ena), .rx_in(rx_in),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: a handshake completes on the posedge following a window where
  // data_valid & data_ready are both seen; each one pops the scoreboard.
  always begin
    @(negedge clk);
    #1;
    if (!reset) begin
      if (frame_err) fe_cnt++;
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_byte: got %0h expected none", data_out);
        end else begin
          check("rx_byte", data_out, exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame starting at a negedge; leaves rx_in at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_in = 1'b0;
    wait_cyc(C);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      wait_cyc(C);
    end
    rx_in = stop_bit;
    wait_cyc(C);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int c0;
    int fe0;

    wait_cyc(3);
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", data_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    wait_cyc(4);

    // 1: basic byte and latency
    data_ready = 1'b1;
    exp_q.push_back(8'hA5);
    lat = -1;
    c0 = cyc;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 0; i < 300; i++) begin
          @(negedge clk);
          #1;
          if (data_valid) begin
            lat = cyc - c0;
            break;
          end
        end
      end
    join
    check("t1_latency", lat, 155);
    wait_cyc(4);
    check("t1_valid_cleared", data_valid, 1'b0);

    // 2: overrun while register full
    data_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    wait_cyc(2);
    check("t2_valid_held", data_valid, 1'b1);
    check("t2_data_held", data_out, 8'h3C);
    check("t2_overrun", overrun, 1'b1);
    data_ready = 1'b1;
    wait_cyc(2);
    check("t2_valid_after_hs", data_valid, 1'b0);
    check("t2_overrun_cleared", overrun, 1'b0);

    // 3: short glitch rejected
    fe0 = fe_cnt;
    rx_in = 1'b0;
    wait_cyc(5);
    rx_in = 1'b1;
    wait_cyc(20);
    check("t3_busy", busy, 1'b0);
    check("t3_valid", data_valid, 1'b0);
    check("t3_frame_err", fe_cnt - fe0, 0);

    // 4: bad stop bit followed by break
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    wait_cyc(40);
    check("t4_busy_in_break", busy, 1'b1);
    check("t4_valid", data_valid, 1'b0);
    rx_in = 1'b1;
    wait_cyc(4);
    check("t4_busy_after_rise", busy, 1'b0);
    check("t4_frame_err_count", fe_cnt - fe0, 1);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    wait_cyc(4);

    // 5: reset mid-frame
    rx_in = 1'b0;
    wait_cyc(C);
    rx_in = 1'b1;
    wait_cyc(4 * C + 8);
    check("t5_busy_before_rst", busy, 1'b1);
    reset = 1'b1;
    wait_cyc(1);
    check("t5_data_out", data_out, 8'h00);
    check("t5_valid", data_valid, 1'b0);
    check("t5_frame_err", frame_err, 1'b0);
    check("t5_overrun", overrun, 1'b0);
    check("t5_busy", busy, 1'b0);
    reset = 1'b0;
    wait_cyc(4 * C);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    wait_cyc(4);

    // 6: enable gating
    ena = 1'b0;
    fork
      send_frame(8'h12, 1'b1);
      begin
        wait_cyc(50);
        check("t6_busy_disabled", busy, 1'b0);
      end
    join
    wait_cyc(4);
    check("t6_valid_disabled", data_valid, 1'b0);
    ena = 1'b1;
    exp_q.push_back(8'h34);
    fork
      send_frame(8'h34, 1'b1);
      begin
        wait_cyc(40);
        ena = 1'b0;
      end
    join
    wait_cyc(4);
    ena = 1'b1;
    wait_cyc(4);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
